clause_ctrl: RTL and testbench
==============================

CLAUSE_CTRL -- requirements
Module: clause_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, meaning cycles waited for the lit-cell free-count chain to settle (1..15).
REQ-002 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request one clause evaluation; sampled only in IDLE.
REQ-006 freelitcnt_i  input  2  free-count at the tail of the lit-cell chain: 0 none free, 1 exactly one free, 3 two or more free.
REQ-007 clausesat_i  input  1  OR of lit-cell clausesat outputs.
REQ-008 cclause_i  input  1  OR of lit-cell cclause outputs during conflict reporting.
REQ-009 conf_ack_i  input  1  conflict analyser has captured the conflict clause.
REQ-010 imp_drv_o  output  1  drive the single free literal to true (to lit-cell imp_drv).
REQ-011 cclause_drv_o  output  1  request lit cells to present conflict-clause membership.
REQ-012 busy_o  output  1  FSM not in IDLE.
REQ-013 done_o  output  1  one-cycle pulse; result_o valid.
REQ-014 result_o  output  2  0 undecided, 1 unit-implied, 2 satisfied, 3 conflict.
REQ-015 conf_valid_o  output  1  cclause_i is meaningful this cycle.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, DECIDE, IMPLY, CONFL, DONE.
REQ-017 IDLE -> SETTLE when start_i=1; settle counter loaded with SETTLE_CYC-1.
REQ-018 SETTLE SHALL decrement counter each cycle; -> DECIDE in the cycle after counter reaches 0 (exactly SETTLE_CYC cycles in SETTLE).
REQ-019 DECIDE priority: clausesat_i=1 -> result 2, DONE; else freelitcnt_i=0 -> result 3, CONFL; else freelitcnt_i=1 -> result 1, IMPLY; else (2 or 3) -> result 0, DONE.
REQ-020 freelitcnt_i=2 (unused encoding) SHALL be treated as two-or-more free.
REQ-021 IMPLY SHALL assert imp_drv_o for exactly one cycle, then -> DONE.
REQ-022 CONFL SHALL hold cclause_drv_o=1 and conf_valid_o=1 (from the cycle after entry) until conf_ack_i=1; on the ack cycle -> DONE, both deassert next cycle.
REQ-023 conf_ack_i outside CONFL SHALL be ignored.
REQ-024 DONE SHALL pulse done_o one cycle, then -> IDLE; result_o SHALL hold until the next DECIDE.
REQ-025 start_i while busy_o=1 SHALL be ignored (no queueing); start_i in the DONE cycle ignored.
REQ-026 Start-to-done latency: SETTLE_CYC+2 cycles (sat/undecided), SETTLE_CYC+3 (unit), SETTLE_CYC+3+ack wait (conflict).
REQ-027 imp_drv_o and cclause_drv_o SHALL never be asserted together.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, counter 0, imp_drv_o=0, cclause_drv_o=0, conf_valid_o=0, busy_o=0, done_o=0, result_o=0.
REQ-029 Reset mid-operation SHALL abort with no done_o pulse and no further imp_drv_o.
REQ-030 First start_i SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-031 Macro CLAUSE_CTRL_STATS_EN defined: SHALL add outputs imp_cnt_o and conf_cnt_o (CNT_W each), incremented on entry to IMPLY / CONFL respectively, saturating at all-ones, reset to 0.
REQ-032 Macro undefined: those outputs and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 SETTLE_CYC=2, clausesat_i=1, start pulse -> done_o 4 cycles later, result_o=2, no imp_drv_o.
REQ-034 clausesat_i=0, freelitcnt_i=1 -> one imp_drv_o pulse, then done_o next cycle, result_o=1; imp_cnt_o=1 with stats enabled.
REQ-035 freelitcnt_i=0, conf_ack_i held low 5 cycles then high -> cclause_drv_o high throughout CONFL, done_o cycle after ack, result_o=3.
REQ-036 freelitcnt_i=3 then repeat with 2 -> both result_o=0, no drive outputs.
REQ-037 start_i repeated while busy -> exactly one done_o; rst=0 during CONFL -> all outputs 0 immediately, no done_o.
REQ-038 Stats enabled, force imp_cnt_o to all-ones via CNT_W=2 and 4 unit evaluations -> imp_cnt_o stays 3.

Source files
------------

// File: rtl/clause_ctrl.sv
// Clause evaluation controller: settles the lit-cell chain, classifies the clause, drives
// the unit implication or conflict report. Define CLAUSE_CTRL_STATS_EN for imp/conf counters.
module clause_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       freelitcnt_i,
   input  logic             clausesat_i,
   input  logic             cclause_i,
   input  logic             conf_ack_i,
   output logic             imp_drv_o,
   output logic             cclause_drv_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       result_o,
   output logic             conf_valid_o,
`ifdef CLAUSE_CTRL_STATS_EN
   output logic [CNT_W-1:0] imp_cnt_o,
   output logic [CNT_W-1:0] conf_cnt_o,
`endif
   output logic [2:0]       state_o
);

   // Handshake: start_i is a request sampled only in IDLE (no queueing); conf_valid_o
   // qualifies cclause_i while in CONFL; conf_ack_i closes the report and is ignored elsewhere.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      DECIDE = 3'd2,
      IMPLY  = 3'd3,
      CONFL  = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [1:0] RES_UNDEC = 2'd0;
   localparam logic [1:0] RES_UNIT  = 2'd1;
   localparam logic [1:0] RES_SAT   = 2'd2;
   localparam logic [1:0] RES_CONF  = 2'd3;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic [1:0] result_q;
   logic [1:0] decide_res;

   // Conflict-clause membership is consumed by the analyser, not by this block.
   logic unused_cclause;
   assign unused_cclause = cclause_i;

   // Encoding 2 of the free count is unused and treated like "two or more".
   always_comb begin
      decide_res = RES_UNDEC;
      if (clausesat_i)
         decide_res = RES_SAT;
      else if (freelitcnt_i == 2'd0)
         decide_res = RES_CONF;
      else if (freelitcnt_i == 2'd1)
         decide_res = RES_UNIT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_i) state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == 4'd0) state_nxt = DECIDE;
         DECIDE: begin
            unique case (decide_res)
               RES_CONF: state_nxt = CONFL;
               RES_UNIT: state_nxt = IMPLY;
               default:  state_nxt = DONE;
            endcase
         end
         IMPLY:   state_nxt = DONE;
         CONFL:   if (conf_ack_i) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imp_drv_o     = 1'b0;
      cclause_drv_o = 1'b0;
      conf_valid_o  = 1'b0;
      done_o        = 1'b0;
      busy_o        = (state != IDLE);
      unique case (state)
         IMPLY: imp_drv_o = 1'b1;
         CONFL: begin
            cclause_drv_o = 1'b1;
            conf_valid_o  = 1'b1;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   // Counter is loaded with SETTLE_CYC-1 so SETTLE lasts exactly SETTLE_CYC cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle_cnt <= 4'd0;
         result_q   <= RES_UNDEC;
      end else begin
         if (state == IDLE && start_i)
            settle_cnt <= 4'(SETTLE_CYC - 1);
         else if (state == SETTLE && settle_cnt != 4'd0)
            settle_cnt <= settle_cnt - 4'd1;
         if (state == DECIDE)
            result_q <= decide_res;
      end
   end

   assign result_o = result_q;
   assign state_o  = state;

`ifdef CLAUSE_CTRL_STATS_EN
   logic [CNT_W-1:0] imp_cnt;
   logic [CNT_W-1:0] conf_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imp_cnt  <= '0;
         conf_cnt <= '0;
      end else if (state == DECIDE) begin
         if (state_nxt == IMPLY && imp_cnt != '1)
            imp_cnt <= imp_cnt + 1'b1;
         if (state_nxt == CONFL && conf_cnt != '1)
            conf_cnt <= conf_cnt + 1'b1;
      end
   end

   assign imp_cnt_o  = imp_cnt;
   assign conf_cnt_o = conf_cnt;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_clause_ctrl.sv
// Scoreboard bench for clause_ctrl: timed driver with a result/latency model, expected
// done events queued and popped by a negedge monitor that also checks per-cycle outputs.
module tb_clause_ctrl;

   localparam int S     = 2;
   localparam int CNT_W = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] freelitcnt_i = 2'd0;
   logic       clausesat_i = 1'b0;
   logic       cclause_i = 1'b0;
   logic       conf_ack_i = 1'b0;
   logic       imp_drv_o, cclause_drv_o, busy_o, done_o, conf_valid_o;
   logic [1:0] result_o;
   logic [2:0] state_o;
`ifdef CLAUSE_CTRL_STATS_EN
   logic [CNT_W-1:0] imp_cnt_o, conf_cnt_o;
`endif

   clause_ctrl #(.SETTLE_CYC(S), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .freelitcnt_i(freelitcnt_i),
      .clausesat_i(clausesat_i), .cclause_i(cclause_i), .conf_ack_i(conf_ack_i),
      .imp_drv_o(imp_drv_o), .cclause_drv_o(cclause_drv_o), .busy_o(busy_o),
      .done_o(done_o), .result_o(result_o), .conf_valid_o(conf_valid_o),
`ifdef CLAUSE_CTRL_STATS_EN
      .imp_cnt_o(imp_cnt_o), .conf_cnt_o(conf_cnt_o),
`endif
      .state_o(state_o)
   );

   // clock/reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state, updated by the driver for each cycle
   int          checks = 0;
   int          failures = 0;
   logic [33:0] exp_q[$];
   logic        exp_busy = 1'b0, exp_imp = 1'b0, exp_ccl = 1'b0;
   logic [1:0]  res_model = 2'd0;
   int          exp_imp_cnt = 0, exp_conf_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] classify(input logic sat, input logic [1:0] flc);
      if (sat) return 2'd2;
      if (flc == 2'd0) return 2'd3;
      if (flc == 2'd1) return 2'd1;
      return 2'd0;
   endfunction

   // driver: one evaluation, inputs held stable, spurious start/ack sprinkled in
   task automatic run_txn(input logic sat, input logic [1:0] flc, input int w);
      logic [1:0] res;
      int c, done_c;
      res = classify(sat, flc);
      c = cyc;
      done_c = c + S + 2 + ((res == 2'd1) ? 1 : 0) + ((res == 2'd3) ? 1 + w : 0);
      clausesat_i = sat;
      freelitcnt_i = flc;
      exp_q.push_back({res, 32'(done_c)});
      for (int t = c; t <= done_c; t++) begin
         start_i  = (t == c) || ($urandom_range(0, 3) == 0);
         cclause_i = 1'($urandom_range(0, 1));
         exp_busy = (t > c);
         exp_imp  = (res == 2'd1) && (t == c + S + 2);
         exp_ccl  = (res == 2'd3) && (t >= c + S + 2) && (t <= c + S + 2 + w);
         if (t == c + S + 2) begin
            res_model = res;
            if (res == 2'd1 && exp_imp_cnt != 3) exp_imp_cnt++;
            if (res == 2'd3 && exp_conf_cnt != 3) exp_conf_cnt++;
         end
         if (res == 2'd3)
            conf_ack_i = (t == c + S + 2 + w) || (t < c + S + 2 && $urandom_range(0, 2) == 0);
         else
            conf_ack_i = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
      end
      start_i = 1'b0; conf_ack_i = 1'b0;
      exp_busy = 1'b0; exp_imp = 1'b0; exp_ccl = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         clausesat_i  = 1'($urandom_range(0, 1));
         freelitcnt_i = 2'($urandom_range(0, 3));
         conf_ack_i   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      conf_ack_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_imp"}, 32'(imp_drv_o), 0);
      chk({tag, "_ccl"}, 32'(cclause_drv_o), 0);
      chk({tag, "_cvalid"}, 32'(conf_valid_o), 0);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_done"}, 32'(done_o), 0);
      chk({tag, "_result"}, 32'(result_o), 0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [33:0] e;
      if (done_o) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected t=%0t actual=1 expected=0", $time);
         end else begin
            e = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), e[31:0]);
            chk("done_result", 32'(result_o), 32'(e[33:32]));
         end
      end
      chk("busy", 32'(busy_o), 32'(exp_busy));
      chk("imp_drv", 32'(imp_drv_o), 32'(exp_imp));
      chk("cclause_drv", 32'(cclause_drv_o), 32'(exp_ccl));
      chk("conf_valid", 32'(conf_valid_o), 32'(exp_ccl));
      chk("result_hold", 32'(result_o), 32'(res_model));
      chk("drive_mutex", 32'(imp_drv_o & cclause_drv_o), 0);
`ifdef CLAUSE_CTRL_STATS_EN
      chk("imp_cnt", 32'(imp_cnt_o), 32'(exp_imp_cnt));
      chk("conf_cnt", 32'(conf_cnt_o), 32'(exp_conf_cnt));
`endif
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      // release reset and start in the same cycle: accepted on the first edge
      rst = 1'b1;
      run_txn(1'b1, 2'd3, 0);
      run_txn(1'b0, 2'd1, 0);
      run_txn(1'b0, 2'd0, 5);
      idle_cycles(2);
      run_txn(1'b0, 2'd3, 0);
      run_txn(1'b0, 2'd2, 0);
      run_txn(1'b1, 2'd0, 0);
      run_txn(1'b0, 2'd0, 0);
      for (int i = 0; i < 4; i++) run_txn(1'b0, 2'd1, 0);
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
         idle_cycles(int'($urandom_range(0, 2)));
      end

      // abort a conflict report with reset
      clausesat_i = 1'b0; freelitcnt_i = 2'd0; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0; exp_busy = 1'b1;
      for (int t = 1; t < S + 4; t++) begin
         if (t == S + 2) begin
            exp_ccl = 1'b1; res_model = 2'd3;
            if (exp_conf_cnt != 3) exp_conf_cnt++;
         end
         @(posedge clk); #1;
      end
      chk("confl_before_reset", 32'(cclause_drv_o), 1);
      #2;
      rst = 1'b0;
      exp_busy = 1'b0; exp_ccl = 1'b0; res_model = 2'd0;
      exp_imp_cnt = 0; exp_conf_cnt = 0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      idle_cycles(6);
      run_txn(1'b0, 2'd1, 0);
      idle_cycles(3);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
